// File: rtl/udp_tx_arbiter_pkg.sv
// Shared encodings, widths and the round-robin successor helper used by the
// UDP TX arbiter and its priority picker.
package udp_tx_arbiter_pkg;

    localparam int BEAT_W = 64;
    localparam int KEEP_W = 8;
    localparam int USER_W = 32;
    localparam int IDX_W  = 3;

    localparam logic [KEEP_W-1:0] KEEP_FULL = 8'hff;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_XFER = 1'b1
    } arb_state_e;

    // Next channel index on a ring of ch_num requesters.
    function automatic logic [IDX_W-1:0] rr_next(input logic [IDX_W-1:0] idx,
                                                input int               ch_num);
        logic [IDX_W-1:0] nxt;
        if (int'(idx) >= ch_num - 1) begin
            nxt = 3'd0;
        end else begin
            nxt = idx + 3'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/udp_tx_arbiter_rr_picker.sv
// Combinational round-robin picker: first request at or after the pointer,
// wrapping from P_N-1 back to 0.
module rr_picker
    import udp_tx_arbiter_pkg::*;
#(
    parameter int P_N = 4
) (
    input  logic [P_N-1:0]   i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [P_N-1:0]   o_grant,
    output logic [IDX_W-1:0] o_idx
);

    localparam int PW = IDX_W + 1;

    logic [PW-1:0] sum_s;
    logic [PW-1:0] pos_s;
    logic          found_s;
    logic          hit_s;

    // Walk the ring starting at the pointer and latch the first requester seen.
    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        found_s = 1'b0;
        hit_s   = 1'b0;
        sum_s   = '0;
        pos_s   = '0;
        for (int i = 0; i < P_N; i++) begin
            sum_s = {1'b0, i_ptr} + PW'(i);
            pos_s = (sum_s >= PW'(P_N)) ? (sum_s - PW'(P_N)) : sum_s;
            for (int k = 0; k < P_N; k++) begin
                hit_s      = !found_s && (pos_s == PW'(k)) && i_req[k];
                o_grant[k] = o_grant[k] | hit_s;
                o_idx      = hit_s ? IDX_W'(k) : o_idx;
                found_s    = found_s | hit_s;
            end
        end
    end

endmodule

// File: rtl/udp_tx_arbiter.sv
// Packet-atomic round-robin arbiter merging P_CH_NUM AXI-Stream channels onto
// the UDP TX stream, with an idle timeout that aborts stalled packets.
module udp_tx_arbiter
    import udp_tx_arbiter_pkg::*;
#(
    parameter int          P_CH_NUM  = 4,
    parameter logic [15:0] P_TIMEOUT = 16'd1024
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic [P_CH_NUM-1:0]        i_ch_enable,
    input  logic [P_CH_NUM*BEAT_W-1:0] s_axis_ch_data,
    input  logic [P_CH_NUM*USER_W-1:0] s_axis_ch_user,
    input  logic [P_CH_NUM*KEEP_W-1:0] s_axis_ch_keep,
    input  logic [P_CH_NUM-1:0]        s_axis_ch_last,
    input  logic [P_CH_NUM-1:0]        s_axis_ch_valid,
    output logic [P_CH_NUM-1:0]        s_axis_ch_ready,
    output logic [BEAT_W-1:0]          m_axis_udp_data,
    output logic [USER_W-1:0]          m_axis_udp_user,
    output logic [KEEP_W-1:0]          m_axis_udp_keep,
    output logic                       m_axis_udp_last,
    output logic                       m_axis_udp_valid,
    input  logic                       m_axis_udp_ready,
    output logic [2:0]                 o_grant_ch,
    output logic                       o_busy,
    output logic                       o_timeout_err
);

    arb_state_e          state_q, state_d;
    logic [IDX_W-1:0]    ptr_q, ptr_d;
    logic [IDX_W-1:0]    grant_q, grant_d;
    logic [15:0]         idle_cnt_q, idle_cnt_d;
    logic                timeout_err_q, timeout_err_d;

    logic [P_CH_NUM-1:0] req_s;
    logic [P_CH_NUM-1:0] pick_onehot_s;
    logic [IDX_W-1:0]    pick_idx_s;
    logic                pick_any_s;

    logic [BEAT_W-1:0]   sel_data_s;
    logic [USER_W-1:0]   sel_user_s;
    logic [KEEP_W-1:0]   sel_keep_s;
    logic                sel_last_s;
    logic                sel_valid_s;
    logic                ch_hit_s;
    logic                busy_s;
    logic                beat_fire_s;
    logic [15:0]         cnt_inc_s;

    assign req_s      = s_axis_ch_valid & i_ch_enable;
    assign pick_any_s = |pick_onehot_s;

    rr_picker #(
        .P_N (P_CH_NUM)
    ) u_rr_picker (
        .i_req   (req_s),
        .i_ptr   (ptr_q),
        .o_grant (pick_onehot_s),
        .o_idx   (pick_idx_s)
    );

    assign busy_s = (state_q == ST_XFER);

    // Route the granted channel to the output and hand it the downstream ready.
    always_comb begin
        sel_data_s      = '0;
        sel_user_s      = '0;
        sel_keep_s      = '0;
        sel_last_s      = 1'b0;
        sel_valid_s     = 1'b0;
        ch_hit_s        = 1'b0;
        s_axis_ch_ready = '0;
        for (int k = 0; k < P_CH_NUM; k++) begin
            ch_hit_s           = (grant_q == IDX_W'(k));
            sel_data_s         = sel_data_s | ({BEAT_W{ch_hit_s}} & s_axis_ch_data[k*BEAT_W +: BEAT_W]);
            sel_user_s         = sel_user_s | ({USER_W{ch_hit_s}} & s_axis_ch_user[k*USER_W +: USER_W]);
            sel_keep_s         = sel_keep_s | ({KEEP_W{ch_hit_s}} & s_axis_ch_keep[k*KEEP_W +: KEEP_W]);
            sel_last_s         = sel_last_s | (ch_hit_s & s_axis_ch_last[k]);
            sel_valid_s        = sel_valid_s | (ch_hit_s & s_axis_ch_valid[k]);
            s_axis_ch_ready[k] = busy_s & ch_hit_s & m_axis_udp_ready;
        end
    end

    // Byte enables only matter on the closing beat; every other beat is full.
    assign m_axis_udp_valid = busy_s & sel_valid_s;
    assign m_axis_udp_last  = busy_s & sel_last_s;
    assign m_axis_udp_data  = busy_s ? sel_data_s : '0;
    assign m_axis_udp_user  = busy_s ? sel_user_s : '0;
    assign m_axis_udp_keep  = m_axis_udp_last ? sel_keep_s : KEEP_FULL;
    assign beat_fire_s      = m_axis_udp_valid & m_axis_udp_ready;

    assign o_grant_ch    = grant_q;
    assign o_busy        = busy_s;
    assign o_timeout_err = timeout_err_q;

    // Next-state logic: grant in IDLE, hold the grant until last beat or timeout.
    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        grant_d       = grant_q;
        idle_cnt_d    = idle_cnt_q;
        timeout_err_d = 1'b0;
        cnt_inc_s     = idle_cnt_q + 16'd1;
        case (state_q)
            ST_IDLE: begin
                idle_cnt_d = 16'd0;
                if (pick_any_s) begin
                    state_d = ST_XFER;
                    grant_d = pick_idx_s;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_XFER: begin
                if (beat_fire_s && m_axis_udp_last) begin
                    state_d    = ST_IDLE;
                    ptr_d      = rr_next(grant_q, P_CH_NUM);
                    idle_cnt_d = 16'd0;
                end else if (sel_valid_s) begin
                    // A stalled downstream with valid data is not an idle source.
                    idle_cnt_d = 16'd0;
                end else if (cnt_inc_s == P_TIMEOUT) begin
                    state_d       = ST_IDLE;
                    ptr_d         = rr_next(grant_q, P_CH_NUM);
                    idle_cnt_d    = 16'd0;
                    timeout_err_d = 1'b1;
                end else begin
                    idle_cnt_d = cnt_inc_s;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                idle_cnt_d = 16'd0;
            end
        endcase
    end

    // State registers with asynchronous reset.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q       <= ST_IDLE;
            ptr_q         <= 3'd0;
            grant_q       <= 3'd0;
            idle_cnt_q    <= 16'd0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            grant_q       <= grant_d;
            idle_cnt_q    <= idle_cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end

endmodule

// File: tb/tb_udp_tx_arbiter.sv
// Directed scoreboard bench for udp_tx_arbiter: per-channel source queues feed
// the DUT while a negedge monitor checks each accepted output beat in order.
module tb_udp_tx_arbiter;

    localparam int          NCH      = 4;
    localparam logic [15:0] TMO      = 16'd8;
    localparam int          DT_ANY   = -1;

    typedef struct {
        logic [63:0] data;
        logic [31:0] user;
        logic [7:0]  keep;
        logic        last;
        int          dly;
    } src_beat_t;

    typedef struct {
        int          ch;
        logic [63:0] data;
        logic [31:0] user;
        logic [7:0]  keep;
        logic        last;
        int          dt;
    } exp_beat_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NCH-1:0]    en  = '1;
    logic [NCH*64-1:0] s_data;
    logic [NCH*32-1:0] s_user;
    logic [NCH*8-1:0]  s_keep;
    logic [NCH-1:0]    s_last;
    logic [NCH-1:0]    s_valid;
    logic [NCH-1:0]    s_ready;
    logic [63:0]       m_data;
    logic [31:0]       m_user;
    logic [7:0]        m_keep;
    logic              m_last;
    logic              m_valid;
    logic              m_ready;
    logic [2:0]        grant;
    logic              busy;
    logic              terr;

    src_beat_t         src_q[NCH][$];
    exp_beat_t         exp_q[$];
    int                dly_left[NCH];
    logic [NCH-1:0]    fire_r = '0;
    bit                ready_toggle = 1'b0;
    int                vec_cnt = 0;
    int                err_cnt = 0;
    int                cyc = 0;
    int                prev_fire = 0;
    int                to_cnt = 0;

    udp_tx_arbiter #(
        .P_CH_NUM  (NCH),
        .P_TIMEOUT (TMO)
    ) dut (
        .i_clk            (clk),
        .i_rst            (rst),
        .i_ch_enable      (en),
        .s_axis_ch_data   (s_data),
        .s_axis_ch_user   (s_user),
        .s_axis_ch_keep   (s_keep),
        .s_axis_ch_last   (s_last),
        .s_axis_ch_valid  (s_valid),
        .s_axis_ch_ready  (s_ready),
        .m_axis_udp_data  (m_data),
        .m_axis_udp_user  (m_user),
        .m_axis_udp_keep  (m_keep),
        .m_axis_udp_last  (m_last),
        .m_axis_udp_valid (m_valid),
        .m_axis_udp_ready (m_ready),
        .o_grant_ch       (grant),
        .o_busy           (busy),
        .o_timeout_err    (terr)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [63:0] mk_data(input int ch, input int pkt, input int beat);
        return 64'hC0DE_0000_0000_0000 | (64'(ch) << 16) | (64'(pkt) << 8) | 64'(beat);
    endfunction

    task automatic exp_only(input int ch, input int pkt, input int beat, input int nbeats, input int dt);
        exp_beat_t e;
        e.ch   = ch;
        e.data = mk_data(ch, pkt, beat);
        e.user = {8'hA5, 8'(ch), 16'(nbeats - 1)};
        e.last = (beat == nbeats - 1);
        e.keep = e.last ? 8'h0f : 8'hff;
        e.dt   = dt;
        exp_q.push_back(e);
    endtask

    task automatic src_only(input int ch, input int pkt, input int beat, input int nbeats, input int dly);
        src_beat_t s;
        s.data = mk_data(ch, pkt, beat);
        s.user = {8'hA5, 8'(ch), 16'(nbeats - 1)};
        s.last = (beat == nbeats - 1);
        s.keep = s.last ? 8'h0f : 8'h5a;
        s.dly  = dly;
        src_q[ch].push_back(s);
    endtask

    task automatic send_pkt(input int ch, input int pkt, input int n, input int first_dt, input int rest_dt);
        for (int b = 0; b < n; b++) begin
            src_only(ch, pkt, b, n, 0);
            exp_only(ch, pkt, b, n, (b == 0) ? first_dt : rest_dt);
        end
    endtask

    task automatic reset_checks(input string tag);
        check({tag, "_busy"},   64'(busy),    64'd0);
        check({tag, "_grant"},  64'(grant),   64'd0);
        check({tag, "_terr"},   64'(terr),    64'd0);
        check({tag, "_sready"}, 64'(s_ready), 64'd0);
        check({tag, "_mvalid"}, 64'(m_valid), 64'd0);
        check({tag, "_mlast"},  64'(m_last),  64'd0);
    endtask

    task automatic do_reset();
        @(posedge clk); #2;
        rst = 1'b1;
        en  = '1;
        ready_toggle = 1'b0;
        for (int k = 0; k < NCH; k++) begin
            src_q[k].delete();
            dly_left[k] = 0;
        end
        exp_q.delete();
        repeat (2) @(posedge clk);
        #2;
        rst    = 1'b0;
        to_cnt = 0;
    endtask

    task automatic drain(input string name, input int budget);
        int n = 0;
        while (exp_q.size() > 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        vec_cnt++;
        if (exp_q.size() != 0) begin
            err_cnt++;
            $display("FAIL %s_drain: %0d beats pending after %0d cycles, expected 0", name, exp_q.size(), n);
        end
    endtask

    // Source model: present each channel's head beat; pop it after the cycle it was accepted.
    initial begin
        s_valid = '0; s_last = '0; s_data = '0; s_user = '0; s_keep = '0;
        m_ready = 1'b1;
        for (int k = 0; k < NCH; k++) dly_left[k] = 0;
        forever begin
            @(posedge clk); #1;
            for (int k = 0; k < NCH; k++) begin
                if (fire_r[k] && src_q[k].size() > 0) begin
                    void'(src_q[k].pop_front());
                    dly_left[k] = (src_q[k].size() > 0) ? src_q[k][0].dly : 0;
                end else if (dly_left[k] > 0) begin
                    dly_left[k]--;
                end
                if (src_q[k].size() > 0 && dly_left[k] == 0) begin
                    s_valid[k]          = 1'b1;
                    s_last[k]           = src_q[k][0].last;
                    s_data[k*64 +: 64]  = src_q[k][0].data;
                    s_user[k*32 +: 32]  = src_q[k][0].user;
                    s_keep[k*8 +: 8]    = src_q[k][0].keep;
                end else begin
                    s_valid[k]          = 1'b0;
                    s_last[k]           = 1'b0;
                    s_data[k*64 +: 64]  = 64'd0;
                    s_user[k*32 +: 32]  = 32'd0;
                    s_keep[k*8 +: 8]    = 8'd0;
                end
            end
            m_ready = ready_toggle ? ~m_ready : 1'b1;
        end
    end

    // Monitor: per-cycle handshake invariants plus in-order scoreboard of output beats.
    initial begin
        exp_beat_t e;
        forever begin
            @(negedge clk);
            fire_r = s_valid & s_ready;
            if (!rst) begin
                if (terr === 1'b1) to_cnt++;
                if (busy) begin
                    check("other_ready", 64'(s_ready & ~(4'b0001 << grant)), 64'd0);
                    check("granted_ready", 64'(s_ready[grant]), 64'(m_ready));
                end else begin
                    check("idle_ready", 64'(s_ready), 64'd0);
                    check("idle_valid", 64'(m_valid), 64'd0);
                end
                if (m_valid && m_ready) begin
                    if (exp_q.size() == 0) begin
                        vec_cnt++;
                        err_cnt++;
                        $display("FAIL unexpected_beat: got ch %0d data %0h, expected no beat", grant, m_data);
                    end else begin
                        e = exp_q.pop_front();
                        check("grant_ch", 64'(grant), 64'(e.ch));
                        check("data", m_data, e.data);
                        check("user", 64'(m_user), 64'(e.user));
                        check("keep", 64'(m_keep), 64'(e.keep));
                        check("last", 64'(m_last), 64'(e.last));
                        if (e.dt != DT_ANY) check("beat_spacing", 64'(cyc - prev_fire), 64'(e.dt));
                    end
                    prev_fire = cyc;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, expected to finish", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state.
        repeat (2) @(negedge clk);
        reset_checks("reset");
        @(posedge clk); #2;
        rst = 1'b0;

        // Single channel 1, 3 beats, last keep 0f, busy drops after last.
        do_reset();
        prev_fire = cyc + 1;
        send_pkt(1, 0, 3, 1, 1);
        drain("single", 40);
        @(negedge clk);
        check("busy_after_last", 64'(busy), 64'd0);

        // All four channels busy: order 0,1,2,3,0 with one idle cycle between packets.
        do_reset();
        prev_fire = cyc + 1;
        send_pkt(0, 0, 2, 1, 1);
        send_pkt(1, 0, 2, 2, 1);
        send_pkt(2, 0, 2, 2, 1);
        send_pkt(3, 0, 2, 2, 1);
        send_pkt(0, 1, 2, 2, 1);
        drain("rr_order", 80);
        check("rr_timeouts", 64'(to_cnt), 64'd0);

        // Channel 2 alone enabled, downstream ready toggling, enable dropped mid-packet.
        do_reset();
        en = 4'b0100;
        ready_toggle = 1'b1;
        src_only(0, 0, 0, 1, 0);
        src_only(1, 0, 0, 1, 0);
        src_only(3, 0, 0, 1, 0);
        send_pkt(2, 0, 10, DT_ANY, DT_ANY);
        repeat (8) @(posedge clk);
        #2;
        en = 4'b0000;
        drain("backpressure", 80);
        repeat (6) @(posedge clk);
        check("bp_timeouts", 64'(to_cnt), 64'd0);

        // Channel 0 stalls after beat 0: timeout after 8 idle cycles, then channel 1.
        do_reset();
        prev_fire = cyc + 1;
        src_only(0, 0, 0, 2, 0);
        src_only(0, 0, 1, 2, 8);
        exp_only(0, 0, 0, 2, 1);
        send_pkt(1, 0, 1, 10, 1);
        exp_only(0, 0, 1, 2, 2);
        drain("timeout", 60);
        check("timeout_pulses", 64'(to_cnt), 64'd1);

        // Only channels 1 and 3 enabled: they alternate.
        do_reset();
        en = 4'b1010;
        prev_fire = cyc + 1;
        for (int k = 0; k < NCH; k++) begin
            src_only(k, 0, 0, 1, 0);
            src_only(k, 1, 0, 1, 0);
        end
        exp_only(1, 0, 0, 1, 1);
        exp_only(3, 0, 0, 1, 2);
        exp_only(1, 1, 0, 1, 2);
        exp_only(3, 1, 0, 1, 2);
        drain("enable_mask", 60);
        repeat (6) @(posedge clk);

        // Reset during beat 1 of channel 3 (pointer previously moved to 2).
        do_reset();
        prev_fire = cyc + 1;
        send_pkt(1, 0, 1, 1, 1);
        drain("pre_reset", 30);
        @(posedge clk); #2;
        prev_fire = cyc + 1;
        src_only(3, 0, 0, 4, 0);
        src_only(3, 0, 1, 4, 0);
        src_only(3, 0, 2, 4, 0);
        src_only(3, 0, 3, 4, 0);
        exp_only(3, 0, 0, 4, 1);
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        check("pre_reset_pending", 64'(exp_q.size()), 64'd0);
        send_pkt(0, 0, 2, DT_ANY, 1);
        exp_only(3, 0, 1, 4, 2);
        exp_only(3, 0, 2, 4, 1);
        exp_only(3, 0, 3, 4, 1);
        @(negedge clk);
        reset_checks("mid_reset");
        @(posedge clk); #2;
        rst = 1'b0;
        drain("post_reset", 40);
        repeat (4) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/udp_tx_arbiter.md
UDP_TX_ARBITER -- requirements
Module: udp_tx_arbiter

Interface
REQ-001 SHALL have parameter P_CH_NUM, default 4, number of user requesters (2..8).
REQ-002 SHALL have parameter P_TIMEOUT, default 16'd1024, idle cycles tolerated inside a granted packet.
REQ-003 i_clk  input  1  clock; all logic on rising edge.
REQ-004 i_rst  input  1  reset, asynchronous, active-high.
REQ-005 i_ch_enable  input  P_CH_NUM  per-channel request mask; 0 = channel never granted.
REQ-006 s_axis_ch_data  input  P_CH_NUM*64  channel n data at [n*64+:64].
REQ-007 s_axis_ch_user  input  P_CH_NUM*32  channel n user at [n*32+:32]; [15:0] = payload length in 64-bit beats minus 1.
REQ-008 s_axis_ch_keep  input  P_CH_NUM*8  byte enables; meaningful on last beat only.
REQ-009 s_axis_ch_last, s_axis_ch_valid  input  P_CH_NUM each  per-channel last/valid.
REQ-010 s_axis_ch_ready  output  P_CH_NUM  per-channel ready.
REQ-011 m_axis_udp_data/user/keep/last/valid  output  64/32/8/1/1  stream to UDP TX.
REQ-012 m_axis_udp_ready  input  1  downstream ready.
REQ-013 o_grant_ch  output  3  index of granted channel; valid while o_busy=1.
REQ-014 o_busy  output  1  high in XFER state.
REQ-015 o_timeout_err  output  1  one-cycle pulse on packet abort.

Function
REQ-016 SHALL implement FSM states IDLE, XFER.
REQ-017 IDLE: candidate set = s_axis_ch_valid & i_ch_enable; if non-empty, SHALL grant first candidate at or after round-robin pointer (wrapping P_CH_NUM-1 -> 0) and enter XFER next cycle.
REQ-018 IDLE: all s_axis_ch_ready and m_axis_udp_valid SHALL be 0.
REQ-019 XFER: m_axis_udp_data/user/keep/last/valid SHALL combinationally equal granted channel's inputs; s_axis_ch_ready[g] = m_axis_udp_ready; other channels' ready = 0.
REQ-020 Beat transfer = m_axis_udp_valid & m_axis_udp_ready; on transfer with last=1 SHALL return to IDLE and set pointer = (g+1) mod P_CH_NUM.
REQ-021 Grant SHALL be packet-atomic: no switch mid-packet, including when i_ch_enable[g] drops during XFER.
REQ-022 Minimum gap between packets SHALL be exactly one IDLE cycle; first beat of a grant transfers no earlier than cycle after grant decision.
REQ-023 Idle counter (16 bit) SHALL count XFER cycles with granted valid=0, clear on any granted valid=1; on reaching P_TIMEOUT SHALL go to IDLE, pulse o_timeout_err, advance pointer as in REQ-020.
REQ-024 m_axis_udp_keep SHALL be 8'hff on non-last beats regardless of input.
REQ-025 Downstream back-pressure (ready=0) SHALL NOT increment idle counter.
REQ-026 Pointer SHALL advance only on grant completion, never on unused IDLE cycles.

Reset
REQ-027 On i_rst: state IDLE, pointer 0, o_grant_ch 0, idle counter 0, o_busy 0, o_timeout_err 0, all ready 0, m_axis_udp_valid 0, m_axis_udp_last 0.
REQ-028 Reset asserted mid-packet SHALL abort at once; after release, arbitration restarts from channel 0 with no residual beats emitted.

Structure
REQ-029 Shared package SHALL hold state encodings (IDLE, XFER), beat width 64, keep width 8, user width 32.
REQ-030 Round-robin priority picker SHALL be one sub-module rr_picker (request vector + pointer -> one-hot grant + index), purely combinational.
REQ-031 Output mux SHALL be combinational; no extra register stage in this block.

Verification
REQ-032 Single channel 1 sends 3-beat packet, ready=1 -> grant=1 one cycle after valid, 3 beats out, last keep=8'h0f passes, o_busy drops after last.
REQ-033 Channels 0..3 all valid continuously, 2-beat packets -> grant order 0,1,2,3,0 with one IDLE cycle between packets.
REQ-034 Channel 2 granted, ready toggles 1/0 for 10 beats -> no beat lost or duplicated, channels 0/1/3 ready=0 throughout, no timeout.
REQ-035 Channel 0 granted, valid drops after beat 1 for P_TIMEOUT=8 cycles -> o_timeout_err pulses once, next grant goes to channel 1.
REQ-036 i_ch_enable=4'b1010 with all valid -> only channels 1 and 3 granted, alternating.
REQ-037 i_rst pulsed during beat 2 of channel 3 packet -> all outputs at reset values, next grant from channel 0.
